serial_word_assembler: RTL and testbench

- Bit-serial to parallel assembler: accepts one bit per handshake beat and assembles WIDTH-bit words.
- Presents each finished word on a one-entry valid/ready output buffer, with a registered all-ones flag.
- It is the receive end of the serial load path that feeds instruction/data words into the single-cycle processor's memories at boot.
- Frame alignment comes from an explicit start marker.

---
 rtl/serial_word_assembler_pkg.sv | 15 +
 rtl/deser_bit_counter.sv | 36 +++
 rtl/serial_word_assembler.sv | 85 ++++++++
 tb/tb_serial_word_assembler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/serial_word_assembler_pkg.sv
// Serial load path constants shared by the receive (assembler) and transmit ends,
// so both sides agree on word width and bit order.
package serial_word_assembler_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam bit LSB_FIRST = 1'b0;
    localparam bit MSB_FIRST = 1'b1;

    // Width of a counter that must hold the values 0..width-1 (width >= 2).
    function automatic int count_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Beat counter for the assembler: wraps at WIDTH-1, with synchronous clear and a
// load-to-1 used when a start marker restarts the frame.
module deser_bit_counter
    import serial_word_assembler_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = count_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load_one,
    output logic [CW-1:0] count,
    output logic          terminal
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    assign terminal = (count == LAST);

    // load_one wins over wrap: a start beat is beat 0, so the next beat is beat 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (load_one) begin
                count <= CW'(1);
            end else if (terminal) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_word_assembler.sv
// Bit-serial to parallel word assembler feeding a one-entry valid/ready output
// buffer with a registered all-ones flag; start marker gives frame alignment.
module serial_word_assembler
    import serial_word_assembler_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = serial_word_assembler_pkg::MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic             s_start,
    output logic             p_valid,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_all_ones,
    output logic             err_resync
);

    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    count;
    logic             terminal;
    logic             beat;
    logic             start_beat;
    logic             complete;
    logic [CW-1:0]    beat_idx;
    logic [CW-1:0]    bit_pos;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;

    // Only the completing bit stalls; earlier bits of the next word may stream in
    // while the previous word is still held.
    assign s_ready    = !(p_valid && !p_ready && terminal);
    assign beat       = s_valid && s_ready;
    assign start_beat = beat && s_start;
    assign complete   = beat && !s_start && terminal;
    assign beat_idx   = start_beat ? '0 : count;
    assign bit_pos    = MSB_FIRST ? (LAST - beat_idx) : beat_idx;

    deser_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk(clk),
        .rst(rst),
        .en(beat),
        .load_one(start_beat),
        .count(count),
        .terminal(terminal)
    );

    // A start beat drops any partial word so no discarded bit can leak through.
    always_comb begin
        next_word = start_beat ? '0 : shift_reg;
        next_word[bit_pos] = s_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg  <= '0;
            p_valid    <= 1'b0;
            p_data     <= '0;
            p_all_ones <= 1'b0;
            err_resync <= 1'b0;
        end else begin
            err_resync <= start_beat && (count != '0);
            if (complete) begin
                shift_reg <= '0;
            end else if (beat) begin
                shift_reg <= next_word;
            end
            if (complete) begin
                p_valid    <= 1'b1;
                p_data     <= next_word;
                p_all_ones <= &next_word;
            end else if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed bench for serial_word_assembler: one MSB-first and one LSB-first
// instance share the same stimulus and are checked against hand-computed words.
module tb_serial_word_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_bit = 1'b0;
    logic       s_start = 1'b0;
    logic       p_ready = 1'b1;

    logic       s_ready_m, p_valid_m, p_all_ones_m, err_resync_m;
    logic [7:0] p_data_m;
    logic       s_ready_l, p_valid_l, p_all_ones_l, err_resync_l;
    logic [7:0] p_data_l;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_m),
        .s_bit(s_bit), .s_start(s_start), .p_valid(p_valid_m), .p_ready(p_ready),
        .p_data(p_data_m), .p_all_ones(p_all_ones_m), .err_resync(err_resync_m)
    );

    serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_l),
        .s_bit(s_bit), .s_start(s_start), .p_valid(p_valid_l), .p_ready(p_ready),
        .p_data(p_data_l), .p_all_ones(p_all_ones_l), .err_resync(err_resync_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Present inputs for one clock edge, then settle 1 time unit past the edge.
    task automatic step(input logic v, input logic b, input logic st);
        s_valid = v;
        s_bit   = b;
        s_start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        vectors++; if (p_valid_m !== 1'b0 || p_valid_l !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_p_valid: got %b/%b expected 0/0", p_valid_m, p_valid_l); end
        vectors++; if (p_data_m !== 8'h00 || p_data_l !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_p_data: got %h/%h expected 00/00", p_data_m, p_data_l); end
        vectors++; if (p_all_ones_m !== 1'b0 || err_resync_m !== 1'b0 || err_resync_l !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flags: got all_ones=%b err=%b/%b expected 0", p_all_ones_m, err_resync_m, err_resync_l); end
        vectors++; if (s_ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_s_ready: got %b expected 1", s_ready_m); end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_msb_frame();
        logic [7:0] w;
        w = 8'hA5;
        p_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i], i == 7);
            vectors++; if (err_resync_m !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_no_resync: beat %0d got %b expected 0", 7 - i, err_resync_m); end
            if (i != 0) begin
                vectors++; if (p_valid_m !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_early_valid: beat %0d got %b expected 0", 7 - i, p_valid_m); end
            end
        end
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'hA5 || p_all_ones_m !== 1'b0) begin miscompares++; $display("[TB] FAIL frame_msb_word: got v=%b d=%h ao=%b expected v=1 d=a5 ao=0", p_valid_m, p_data_m, p_all_ones_m); end
        vectors++; if (p_data_l !== 8'hA5) begin miscompares++; $display("[TB] FAIL frame_lsb_word: got %h expected a5", p_data_l); end
        idle();
        vectors++; if (p_valid_m !== 1'b0 || p_data_m !== 8'hA5) begin miscompares++; $display("[TB] FAIL frame_drain: got v=%b d=%h expected v=0 d=a5", p_valid_m, p_data_m); end
    endtask

    task automatic test_lsb_order();
        logic [7:0] w;
        p_ready = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        vectors++; if (p_valid_l !== 1'b1 || p_data_l !== 8'hFF || p_all_ones_l !== 1'b1) begin miscompares++; $display("[TB] FAIL lsb_ones: got v=%b d=%h ao=%b expected v=1 d=ff ao=1", p_valid_l, p_data_l, p_all_ones_l); end
        vectors++; if (p_all_ones_m !== 1'b1) begin miscompares++; $display("[TB] FAIL msb_ones_flag: got %b expected 1", p_all_ones_m); end
        w = 8'b0000_0001;
        for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0);
        vectors++; if (p_valid_l !== 1'b1 || p_data_l !== 8'h01 || p_all_ones_l !== 1'b0) begin miscompares++; $display("[TB] FAIL lsb_second: got v=%b d=%h ao=%b expected v=1 d=01 ao=0", p_valid_l, p_data_l, p_all_ones_l); end
        vectors++; if (p_data_m !== 8'h80 || p_all_ones_m !== 1'b0) begin miscompares++; $display("[TB] FAIL msb_second: got d=%h ao=%b expected d=80 ao=0", p_data_m, p_all_ones_m); end
        idle();
    endtask

    task automatic test_stall();
        logic [7:0] w;
        p_ready = 1'b0;
        w = 8'h3C;
        for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0);
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'h3C || p_data_l !== 8'h3C) begin miscompares++; $display("[TB] FAIL stall_hold: got v=%b d=%h/%h expected v=1 d=3c/3c", p_valid_m, p_data_m, p_data_l); end
        w = 8'hF0;
        for (int i = 7; i >= 1; i--) begin
            vectors++; if (s_ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_early_ready: bit %0d got %b expected 1", 7 - i, s_ready_m); end
            step(1'b1, w[i], 1'b0);
        end
        vectors++; if (s_ready_m !== 1'b0 || s_ready_l !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_ready_low: got %b/%b expected 0/0", s_ready_m, s_ready_l); end
        step(1'b1, w[0], 1'b0);
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'h3C || s_ready_m !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_stable: got v=%b d=%h rdy=%b expected v=1 d=3c rdy=0", p_valid_m, p_data_m, s_ready_m); end
        p_ready = 1'b1;
        #1;
        vectors++; if (s_ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_release_ready: got %b expected 1", s_ready_m); end
        step(1'b1, w[0], 1'b0);
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'hF0 || p_data_l !== 8'h0F) begin miscompares++; $display("[TB] FAIL stall_new_word: got v=%b d=%h/%h expected v=1 d=f0/0f", p_valid_m, p_data_m, p_data_l); end
        idle();
        vectors++; if (p_valid_m !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_drain: got %b expected 0", p_valid_m); end
    endtask

    task automatic test_resync();
        logic [7:0] w;
        p_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        vectors++; if (err_resync_m !== 1'b0) begin miscompares++; $display("[TB] FAIL resync_unqualified: got %b expected 0", err_resync_m); end
        w = 8'h5A;
        step(1'b1, w[7], 1'b1);
        vectors++; if (err_resync_m !== 1'b1 || err_resync_l !== 1'b1) begin miscompares++; $display("[TB] FAIL resync_pulse: got %b/%b expected 1/1", err_resync_m, err_resync_l); end
        step(1'b1, w[6], 1'b0);
        vectors++; if (err_resync_m !== 1'b0) begin miscompares++; $display("[TB] FAIL resync_one_cycle: got %b expected 0", err_resync_m); end
        for (int i = 5; i >= 0; i--) step(1'b1, w[i], 1'b0);
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'h5A || p_data_l !== 8'h5A) begin miscompares++; $display("[TB] FAIL resync_word: got v=%b d=%h/%h expected v=1 d=5a/5a", p_valid_m, p_data_m, p_data_l); end
        idle();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] w;
        p_ready = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, i == 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, i == 0);
        vectors++; if (p_valid_m !== 1'b1 || p_all_ones_m !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_pre: got v=%b ao=%b expected 1/1", p_valid_m, p_all_ones_m); end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        vectors++; if (p_valid_m !== 1'b0 || p_data_m !== 8'h00 || p_all_ones_m !== 1'b0 || err_resync_m !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_clear: got v=%b d=%h ao=%b err=%b expected all 0", p_valid_m, p_data_m, p_all_ones_m, err_resync_m); end
        p_ready = 1'b1;
        w = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0);
            vectors++; if (err_resync_m !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_no_resync: beat %0d got %b expected 0", 7 - i, err_resync_m); end
        end
        vectors++; if (p_valid_m !== 1'b1 || p_data_m !== 8'h81 || p_all_ones_m !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_fresh: got v=%b d=%h ao=%b expected v=1 d=81 ao=0", p_valid_m, p_data_m, p_all_ones_m); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4];
        logic [7:0] w;
        int pulses;
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56; words[3] = 8'h78;
        pulses = 0;
        p_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            w = words[n];
            for (int i = 7; i >= 0; i--) begin
                vectors++; if (s_ready_m !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready: word %0d bit %0d got %b expected 1", n, 7 - i, s_ready_m); end
                step(1'b1, w[i], n == 0 && i == 7);
                if (p_valid_m === 1'b1) pulses++;
                if (i == 0) begin
                    vectors++; if (p_valid_m !== 1'b1 || p_data_m !== w || p_data_l !== rev8(w)) begin miscompares++; $display("[TB] FAIL b2b_word: word %0d got v=%b d=%h/%h expected v=1 d=%h/%h", n, p_valid_m, p_data_m, p_data_l, w, rev8(w)); end
                end else begin
                    vectors++; if (p_valid_m !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap: word %0d bit %0d got v=%b expected 0", n, 7 - i, p_valid_m); end
                end
            end
        end
        vectors++; if (pulses != 4) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d words expected 4", pulses); end
        idle();
    endtask

    initial begin
        test_reset();
        test_msb_frame();
        test_lsb_order();
        test_stall();
        test_resync();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
